// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_packer
// Description : Reads a synchronous FIFO and absorbs its one-cycle read
//               latency. It packs LANES entries into one wide word, presented
//               on a valid/ready master port. A flush closes a partial word
//               with a lane-keep mask and a last marker.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = $clog2(LANES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fifo_empty,
  input  logic [DATA_WIDTH-1:0]       fifo_dout,
  output logic                        fifo_rd_en,
  input  logic                        flush,
  output logic [DATA_WIDTH*LANES-1:0] m_data,
  output logic [LANES-1:0]            m_keep,
  output logic                        m_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        busy
);

  localparam int                   ACC_WIDTH   = DATA_WIDTH * LANES;
  localparam logic [CNT_WIDTH-1:0] c_LANES_CNT = CNT_WIDTH'(LANES);
  localparam logic [CNT_WIDTH:0]   c_LANES_EXT = (CNT_WIDTH + 1)'(LANES);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_inflight;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_m_data;
  logic [LANES-1:0]      r_m_keep;
  logic                  r_m_last;
  logic                  r_m_valid;

  logic                  w_flush_pend;
  logic                  w_cnt_full;
  logic                  w_close_flush;
  logic                  w_xfer;
  logic [CNT_WIDTH:0]    w_occ;
  logic                  w_rd_en;
  logic [CNT_WIDTH-1:0]  w_cnt_base;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [LANES-1:0]      w_keep;
  logic [ACC_WIDTH-1:0]  w_word;
  logic [ACC_WIDTH-1:0]  w_acc_nxt;

  // The DRAIN state is the pending-flush condition: reads stay off until the
  // partial word has been closed.
  assign w_flush_pend = (r_state == ST_DRAIN);
  assign w_cnt_full   = (r_cnt == c_LANES_CNT);

  // A word is closed by flush either once the drain has settled with data in
  // the accumulator, or when the flush lands on an already full accumulator.
  assign w_close_flush = (w_flush_pend && !r_inflight && (r_cnt != '0)) ||
                         (!w_flush_pend && flush && w_cnt_full);

  assign w_xfer = (w_cnt_full || w_close_flush) && (!r_m_valid || m_ready);

  // Entries already owned by the packer: captured ones plus the one in flight.
  assign w_occ = {1'b0, r_cnt} + {{CNT_WIDTH{1'b0}}, r_inflight};

  // A read is issued only if its data has a lane to land in. When the
  // accumulator empties this cycle, that lane is lane 0. Held low in reset.
  assign w_rd_en = rst_n && !fifo_empty && !w_flush_pend &&
                   ((w_occ < c_LANES_EXT) || (w_xfer && !r_inflight));

  // An arriving byte lands after any word that leaves on the same edge.
  assign w_cnt_base = w_xfer ? '0 : r_cnt;
  assign w_cnt_nxt  = w_cnt_base + CNT_WIDTH'(r_inflight);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_keep[i] = (r_cnt > CNT_WIDTH'(i));
    assign w_word[i*DATA_WIDTH +: DATA_WIDTH] =
      w_keep[i] ? r_acc[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign w_acc_nxt[i*DATA_WIDTH +: DATA_WIDTH] =
      (r_inflight && (w_cnt_base == CNT_WIDTH'(i))) ? fifo_dout :
      (w_xfer ? '0 : r_acc[i*DATA_WIDTH +: DATA_WIDTH]);
  end

  // Flush FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush FSM next state: DRAIN waits out the in-flight read, then closes
  // the partial word (or returns directly when nothing was collected).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: begin
        // A full word closed by this very flush needs no drain phase.
        if (flush && !w_xfer) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!r_inflight && ((r_cnt == '0) || w_xfer)) begin
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // Read-latency tracking and accumulator fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
    end else begin
      r_inflight <= w_rd_en;
      r_cnt      <= w_cnt_nxt;
      r_acc      <= w_acc_nxt;
    end
  end

  // Output register: loads on a word transfer, otherwise holds until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
    end else if (w_xfer) begin
      r_m_data  <= w_word;
      r_m_keep  <= w_keep;
      r_m_last  <= w_close_flush;
      r_m_valid <= 1'b1;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign m_data     = r_m_data;
  assign m_keep     = r_m_keep;
  assign m_last     = r_m_last;
  assign m_valid    = r_m_valid;
  assign busy       = (r_cnt != '0) || r_inflight || w_flush_pend || r_m_valid;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_packer
// Description : Self-checking bench for fifo_rd_packer with a behavioural
//               one-cycle-latency FIFO, an output word monitor and a table of
//               expected words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        busy;

  always #5 clk = ~clk;

  fifo_rd_packer #(
    .DATA_WIDTH (8),
    .LANES      (4)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy)
  );

  // Behavioural FIFO: data appears the cycle after an accepted read.
  logic [7:0] q[$];
  int         pops = 0;
  int         cyc  = 0;
  always @(posedge clk) begin
    logic [7:0] b;
    cyc <= cyc + 1;
    if (fifo_rd_en && !fifo_empty) begin
      b = q.pop_front();
      fifo_dout  <= b;
      pops       <= pops + 1;
    end
    fifo_empty <= (q.size() == 0);
  end

  // Output monitor: records every accepted word and its cycle.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;
  word_t got[$];
  int    got_cyc[$];
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      got.push_back({m_data, m_keep, m_last});
      got_cyc.push_back(cyc);
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } vec_t;
  vec_t exp_tab[10];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
  endtask

  task automatic wait_words(input int n, input int budget, input string nm);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (got.size() < n) begin
      n_chk++;
      $display("FAIL %s timeout: words %0d expected %0d", nm, got.size(), n);
    end
  endtask

  task automatic wait_pops(input int target, input int budget, input string nm);
    int k = 0;
    while (pops < target && k < budget) begin
      step(1);
      k++;
    end
    if (pops < target) begin
      n_chk++;
      $display("FAIL %s timeout: reads %0d expected %0d", nm, pops, target);
    end
  endtask

  initial begin
    int base;
    exp_tab[0] = '{"t1_w0",  32'h44332211, 4'hF, 1'b0};
    exp_tab[1] = '{"t2_w0",  32'h04030201, 4'hF, 1'b0};
    exp_tab[2] = '{"t2_w1",  32'h08070605, 4'hF, 1'b0};
    exp_tab[3] = '{"t2_w2",  32'h0C0B0A09, 4'hF, 1'b0};
    exp_tab[4] = '{"t3_w0",  32'h24232221, 4'hF, 1'b0};
    exp_tab[5] = '{"t3_w1",  32'h28272625, 4'hF, 1'b0};
    exp_tab[6] = '{"t3_w2",  32'h2C2B2A29, 4'hF, 1'b0};
    exp_tab[7] = '{"t4_part", 32'h00C3B2A1, 4'h7, 1'b1};
    exp_tab[8] = '{"t4_next", 32'h54535251, 4'hF, 1'b0};
    exp_tab[9] = '{"t6_clean", 32'h64636261, 4'hF, 1'b0};

    // Reset state
    step(2);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Test 1: one full word, exactly four reads
    base = pops;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_words(1, 40, "t1_word");
    step(3);
    chk("t1_words", got.size(), 1);
    chk("t1_reads", pops - base, 4);

    // Test 2: streaming, 5-cycle word spacing, busy drops after the tail
    for (int i = 1; i <= 12; i++) push(8'(i));
    wait_words(4, 80, "t2_words");
    @(negedge clk);
    chk("t2_busy_idle", busy, 0);
    chk("t2_fifo_drained", q.size(), 0);
    if (got_cyc.size() >= 4) begin
      chk("t2_spacing_1", got_cyc[2] - got_cyc[1], 5);
      chk("t2_spacing_2", got_cyc[3] - got_cyc[2], 5);
    end
    step(2);
    chk("t2_words", got.size(), 4);

    // Test 3: backpressure holds word, accumulator fills, reads stop
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(8'h21 + 8'(i));
    step(25);
    @(negedge clk);
    chk("t3_m_valid", m_valid, 1);
    chk("t3_held_data", m_data, 32'h24232221);
    chk("t3_held_keep", m_keep, 4'hF);
    chk("t3_rd_en_off", fifo_rd_en, 0);
    chk("t3_fifo_left", q.size(), 1);
    step(3);
    @(negedge clk);
    chk("t3_still_held", m_data, 32'h24232221);
    chk("t3_no_accept", got.size(), 4);
    step(1);
    m_ready = 1'b1;
    push(8'h2A); push(8'h2B); push(8'h2C);
    wait_words(7, 60, "t3_words");
    step(2);

    // Test 4: flush in the cycle the third byte arrives
    base = pops;
    push(8'hA1); push(8'hB2); push(8'hC3);
    wait_pops(base + 3, 40, "t4_reads");
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    wait_words(8, 20, "t4_partial");
    step(1);
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    wait_words(9, 40, "t4_next");
    step(3);

    // Test 5: flush with nothing collected emits no word
    @(negedge clk);
    chk("t5_idle_busy", busy, 0);
    step(1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    @(negedge clk);
    chk("t5_drain_busy", busy, 1);
    step(1);
    @(negedge clk);
    chk("t5_back_idle", busy, 0);
    step(3);
    chk("t5_no_word", got.size(), 9);

    // Test 6: async reset mid-word with a read in flight and m_valid high
    m_ready = 1'b0;
    base = pops;
    for (int i = 0; i < 7; i++) push(8'h71 + 8'(i));
    wait_pops(base + 7, 60, "t6_reads");
    chk("t6_pre_valid", m_valid, 1);
    chk("t6_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_m_valid", m_valid, 0);
    chk("t6_m_data", m_data, 0);
    chk("t6_m_keep", m_keep, 0);
    chk("t6_m_last", m_last, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rd_en", fifo_rd_en, 0);
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    step(2);
    @(negedge clk);
    chk("t6_rd_en_in_reset", fifo_rd_en, 0);
    step(1);
    m_ready = 1'b1;
    rst_n   = 1'b1;
    wait_words(10, 40, "t6_word");
    step(3);
    chk("total_words", got.size(), 10);

    // Compare every captured word against the expected table
    for (int i = 0; i < 10; i++) begin
      word_t w;
      w = (i < got.size()) ? got[i] : '0;
      chk({exp_tab[i].tag, "_data"}, w.data, exp_tab[i].data);
      chk({exp_tab[i].tag, "_keep"}, w.keep, exp_tab[i].keep);
      chk({exp_tab[i].tag, "_last"}, w.last, exp_tab[i].last);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
